// File: rtl/pes_seq_mul_pkg.sv
// Shared types and defaults for the sequential-multiplier arbiter slice.
// Holds the FSM state enum, default widths and the ID-width helper.
package pes_seq_mul_pkg;

   localparam int W_DEF       = 8;
   localparam int N_DEF       = 4;
   localparam int TIMEOUT_DEF = 31;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      WAIT,
      RESP
   } state_t;

   // Never narrower than one bit so a 2-requester build still has an ID field.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pes_seq_mul_arb_if.sv
// Requester, response and multiplier signals of the shared-multiplier arbiter.
// slave = arbiter side, master = requesters plus multiplier side.
interface pes_seq_mul_arb_if
   import pes_seq_mul_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
);
   localparam int IW = clog2(N);

   logic [N-1:0]   req;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic [IW-1:0]  rsp_id;
   logic [2*W-1:0] rsp_p;
   logic           rsp_err;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic           mul_load;
   logic [2*W-1:0] mul_p;
   logic           mul_valid;

   modport slave (
      input  req, req_a, req_b, mul_p, mul_valid,
      output gnt, rsp_valid, rsp_id, rsp_p, rsp_err, mul_a, mul_b, mul_load
   );

   modport master (
      output req, req_a, req_b, mul_p, mul_valid,
      input  gnt, rsp_valid, rsp_id, rsp_p, rsp_err, mul_a, mul_b, mul_load
   );

endinterface

// File: rtl/pes_rr_arb.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo N.
// No state; the pointer register lives in the parent.
module pes_rr_arb #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] id
);
   int           idx;
   logic [N-1:0] sh;

   // Scan farthest candidate first so the nearest one after ptr is the last write.
   always_comb begin
      found = 1'b0;
      id    = '0;
      idx   = 0;
      sh    = '0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N;
         sh  = req >> idx;
         if (sh[0]) begin
            found = 1'b1;
            id    = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/pes_seq_mul_arb.sv
// Round-robin share of one sequential multiplier among N requesters, with a watchdog abort.
// gnt/mul_load one cycle after req seen in IDLE, rsp one cycle after mul_valid; requesters hold req until gnt.
module pes_seq_mul_arb
   import pes_seq_mul_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   pes_seq_mul_arb_if.slave bus,
   output logic             busy,
   output logic             timeout_err
);
   localparam int IW = clog2(N);

   state_t         state, state_nx;
   logic [IW-1:0]  ptr, id, pick_id;
   logic           pick_found;
   logic [7:0]     wd;
   logic           wd_hit;
   logic [W-1:0]   a_q, b_q;
   logic [2*W-1:0] p_q;
   logic           err_q;

   pes_rr_arb #(.N(N), .IW(IW)) u_rr (
      .req   (bus.req),
      .ptr   (ptr),
      .found (pick_found),
      .id    (pick_id)
   );

   assign wd_hit      = (wd == 8'(TIMEOUT));
   assign bus.mul_a   = a_q;
   assign bus.mul_b   = b_q;
   assign bus.rsp_id  = id;
   assign bus.rsp_p   = p_q;
   assign bus.rsp_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.gnt       = '0;
      bus.mul_load  = 1'b0;
      bus.rsp_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (pick_found) state_nx = LOAD;
         end
         LOAD: begin
            bus.mul_load = 1'b1;
            bus.gnt      = N'(1) << id;
            state_nx     = SETTLE;
         end
         // A stale mul_valid from the previous operation may still be high here.
         SETTLE: state_nx = WAIT;
         WAIT: begin
            if (bus.mul_valid || wd_hit) state_nx = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= IW'(N - 1);
         id          <= '0;
         a_q         <= '0;
         b_q         <= '0;
         p_q         <= '0;
         err_q       <= 1'b0;
         timeout_err <= 1'b0;
         wd          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  id  <= pick_id;
                  a_q <= W'(bus.req_a >> (int'(pick_id) * W));
                  b_q <= W'(bus.req_b >> (int'(pick_id) * W));
               end
            end
            LOAD:   ptr <= id;
            SETTLE: wd  <= '0;
            WAIT: begin
               // A valid arriving on the watchdog's last cycle still wins.
               if (bus.mul_valid) begin
                  p_q   <= bus.mul_p;
                  err_q <= 1'b0;
               end else if (wd_hit) begin
                  p_q         <= '0;
                  err_q       <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  wd <= wd + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pes_seq_mul_arb.sv
// Bench for pes_seq_mul_arb: vector table, hand-written corner sequences and random rounds
// against a transaction-level round-robin/product model and a behavioural multiplier.
module tb_pes_seq_mul_arb;
   import pes_seq_mul_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 31;

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      int         p;
   } vec_t;

   typedef struct {
      int id;
      int p;
      bit err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic timeout_err;

   pes_seq_mul_arb_if #(.N(N), .W(W)) bus ();

   pes_seq_mul_arb #(.N(N), .W(W), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: result after m_lat cycles; valid stays high until
   // one cycle after the next load, so the arbiter sees a stale valid in SETTLE.
   logic [15:0] m_p;
   logic        m_vld;
   logic [7:0]  ld_a, ld_b;
   int          m_cnt;
   int          m_lat;
   bit          m_never;

   always @(posedge clk) begin
      if (rst) begin
         m_vld <= 1'b0;
         m_p   <= '0;
         m_cnt <= 0;
      end else if (bus.mul_load) begin
         ld_a  <= bus.mul_a;
         ld_b  <= bus.mul_b;
         m_cnt <= m_lat;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         m_vld <= 1'b0;
         if (m_cnt == 1 && !m_never) begin
            m_vld <= 1'b1;
            m_p   <= 16'(ld_a) * 16'(ld_b);
         end
      end
   end

   assign bus.mul_p     = m_p;
   assign bus.mul_valid = m_vld;

   int         checks = 0;
   int         errors = 0;
   int         model_ptr;
   bit         hold;
   int         first_gnt;
   logic [7:0] opa[N];
   logic [7:0] opb[N];
   int         prod[N];
   int         gexp[$];
   exp_t       expq[$];
   int         gseen[$];
   vec_t       tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*W +: W] = opa[i];
         bus.req_b[i*W +: W] = opb[i];
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int p);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (p + k) % N;
         if (((m >> j) & 1) != 0) return j;
      end
      return -1;
   endfunction

   // Requesters drop on grant, so the set at each arbitration is what is still pending.
   task automatic plan(input logic [N-1:0] mask);
      logic [N-1:0] m;
      int w;
      m = mask;
      while (m != '0) begin
         w = rr_pick(m, model_ptr);
         gexp.push_back(w);
         expq.push_back('{w, prod[w], 1'b0});
         m = m & ~(N'(1) << w);
         model_ptr = w;
      end
   endtask

   task automatic plan_hold(input int n);
      int w;
      for (int k = 0; k < n; k++) begin
         w = rr_pick('1, model_ptr);
         gexp.push_back(w);
         expq.push_back('{w, prod[w], 1'b0});
         model_ptr = w;
      end
   endtask

   task automatic run(input int n_rsp, input int budget);
      int got, cyc, gcyc, gid, exp_lat;
      logic [N-1:0] prev;
      exp_t e;
      got = 0; cyc = 0; gcyc = 0; prev = '0; first_gnt = -1;
      while (got < n_rsp && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus.gnt != '0) begin
            gid = -1;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) gid = i;
            chk("gnt_onehot", 64'($onehot(bus.gnt)), 1);
            chk("gnt_pulse", 64'(prev), 0);
            chk("gnt_id", 64'(gid), 64'((gexp.size() > 0) ? gexp.pop_front() : -1));
            chk("mul_load", 64'(bus.mul_load), 1);
            chk("mul_a", 64'(bus.mul_a), 64'(opa[gid]));
            chk("mul_b", 64'(bus.mul_b), 64'(opb[gid]));
            gseen.push_back(gid);
            gcyc = cyc;
            if (first_gnt < 0) first_gnt = cyc;
            if (!hold) bus.req[gid] = 1'b0;
         end
         if (bus.rsp_valid) begin
            if (expq.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e = expq.pop_front();
               exp_lat = m_never ? TO + 3 : m_lat + 2;
               chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
               chk("rsp_p", 64'(bus.rsp_p), 64'(e.p));
               chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
               chk("rsp_lat", 64'(cyc - gcyc), 64'(exp_lat));
            end
            got++;
            if (got == n_rsp && hold) bus.req = '0;
         end
         prev = bus.gnt;
      end
      chk("rsp_count", 64'(got), 64'(n_rsp));
   endtask

   task automatic single(input vec_t v);
      opa[v.id]  = v.a;
      opb[v.id]  = v.b;
      prod[v.id] = v.p;
      drive_ops();
      plan(N'(1) << v.id);
      bus.req = N'(1) << v.id;
      run(1, 200);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      model_ptr = N - 1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_gnt", 64'(bus.gnt), 0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 0);
      chk("rst_rsp_p", 64'(bus.rsp_p), 0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_timeout_err", 64'(timeout_err), 0);
      chk("rst_mul_a", 64'(bus.mul_a), 0);
      chk("rst_mul_b", 64'(bus.mul_b), 0);
      chk("rst_mul_load", 64'(bus.mul_load), 0);
   endtask

   initial begin
      int seen, gid;
      logic [N-1:0] mask;

      rst = 1'b1; bus.req = '0; bus.req_a = '0; bus.req_b = '0;
      m_lat = 3; m_never = 1'b0; hold = 1'b0;
      for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; prod[i] = 0; end

      tbl[0] = '{0, 8'd25,  8'd5,   125};
      tbl[1] = '{1, 8'd11,  8'd33,  363};
      tbl[2] = '{2, 8'd128, 8'd0,   0};
      tbl[3] = '{3, 8'd80,  8'd10,  800};
      tbl[4] = '{0, 8'd255, 8'd255, 65025};
      tbl[5] = '{1, 8'd36,  8'd36,  1296};
      tbl[6] = '{0, 8'd64,  8'd64,  4096};
      tbl[7] = '{3, 8'd36,  8'd36,  1296};

      do_reset();
      chk_reset_outputs();

      // Single op: grant one cycle after req, busy drops afterwards.
      single(tbl[4]);
      chk("gnt_latency", 64'(first_gnt), 1);
      @(negedge clk);
      chk("busy_after", 64'(busy), 0);

      // All four request at once from reset: grants 0,1,2,3.
      do_reset();
      gseen.delete();
      for (int i = 0; i < 4; i++) begin
         opa[tbl[i].id]  = tbl[i].a;
         opb[tbl[i].id]  = tbl[i].b;
         prod[tbl[i].id] = tbl[i].p;
      end
      drive_ops();
      plan(4'hF);
      bus.req = 4'hF;
      run(4, 200);
      for (int k = 0; k < 4; k++) chk("group_order", 64'(gseen[k]), 64'(k));

      // Leave the pointer at 1, then hold every req for 8 operations.
      single(tbl[5]);
      hold = 1'b1;
      gseen.delete();
      for (int i = 0; i < N; i++) begin
         opa[i]  = 8'($urandom_range(0, 255));
         opb[i]  = 8'($urandom_range(0, 255));
         prod[i] = int'(opa[i]) * int'(opb[i]);
      end
      drive_ops();
      plan_hold(8);
      bus.req = '1;
      run(8, 400);
      hold = 1'b0;
      for (int k = 0; k < 8; k++) chk("fair_order", 64'(gseen[k]), 64'((k + 2) % 4));

      // Back-to-back op while the previous valid is still high.
      m_lat = 1;
      single(tbl[6]);

      // Watchdog expiry, then a normal op with the sticky flag still set.
      m_never = 1'b1;
      m_lat   = 3;
      opa[2] = 8'd9; opb[2] = 8'd9;
      drive_ops();
      gexp.push_back(2);
      expq.push_back('{2, 0, 1'b1});
      model_ptr = 2;
      bus.req = 4'b0100;
      run(1, 100);
      chk("timeout_err_set", 64'(timeout_err), 1);
      m_never = 1'b0;
      single(tbl[7]);
      chk("timeout_err_sticky", 64'(timeout_err), 1);

      // Reset while waiting on the multiplier: no response, requester 0 first afterwards.
      m_never = 1'b1;
      opa[2] = 8'd7; opb[2] = 8'd7;
      drive_ops();
      bus.req = 4'b0100;
      gid = 0;
      for (int c = 0; c < 10 && gid == 0; c++) begin
         @(negedge clk);
         if (bus.gnt != '0) gid = 1;
      end
      chk("wait_gnt", 64'(bus.gnt), 64'(4'b0100));
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("wait_busy", 64'(busy), 1);
      seen = 0;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      rst = 1'b0;
      model_ptr = N - 1;
      chk_reset_outputs();
      repeat (40) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      chk("abort_no_rsp", 64'(seen), 0);
      m_never = 1'b0;
      for (int i = 0; i < N; i++) prod[i] = int'(opa[i]) * int'(opb[i]);
      plan(4'hF);
      bus.req = 4'hF;
      run(4, 200);

      // Random rounds against the transaction model.
      for (int r = 0; r < 20; r++) begin
         m_lat = $urandom_range(1, 6);
         mask  = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            opa[i]  = 8'($urandom_range(0, 255));
            opb[i]  = 8'($urandom_range(0, 255));
            prod[i] = int'(opa[i]) * int'(opb[i]);
         end
         drive_ops();
         plan(mask);
         bus.req = mask;
         run($countones(mask), 300);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pes_seq_mul_arb.md
Name: pes_seq_mul_arb

Overview:
Shares one pes_seq_mul sequential multiplier between N requesters using round-robin arbitration. Captures the winning requester's operands and pulses the multiplier's load. Waits for the multiplier's valid and returns the 2W-bit product tagged with the requester ID. A watchdog aborts an operation if valid never arrives.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand width; product width is 2*W
TIMEOUT, 31, max cycles spent in WAIT before abort (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N  per-requester request level; held until matching gnt bit seen
req_a  in  N*W  operand A per requester, slice i = [i*W +: W]
req_b  in  N*W  operand B per requester, same slicing
gnt  out  N  one-hot, one-cycle pulse: operands of that requester have been captured
rsp_valid  out  1  one-cycle pulse: result available
rsp_id  out  clog2(N)  requester index of the result
rsp_p  out  2*W  product (0 when rsp_err=1)
rsp_err  out  1  qualifies rsp_valid: operation timed out
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky, set on any timeout, cleared only by rst
mul_a  out  W  operand A to multiplier
mul_b  out  W  operand B to multiplier
mul_load  out  1  one-cycle start pulse to multiplier
mul_p  in  2*W  multiplier product
mul_valid  in  1  multiplier done; may stay high after completion

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; gnt=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, busy=0, timeout_err=0, mul_a=0, mul_b=0, mul_load=0; RR pointer=N-1, so requester 0 has first priority; watchdog=0.
- rst mid-operation: aborts immediately with no response. The multiplier shares rst and aborts with it.
- States: IDLE, LOAD, SETTLE, WAIT, RESP.
- IDLE, req!=0:
  - Select the first set bit searching pointer+1, pointer+2, ... with wrap modulo N.
  - Register mul_a/mul_b from that requester's slices and store its ID; go to LOAD.
- IDLE, req=0: stay.
- LOAD (1 cycle): mul_load=1 and gnt[id]=1; pointer<=id; go to SETTLE.
- SETTLE (1 cycle): mul_valid is ignored, because a stale valid from the previous op may still be high; watchdog cleared; go to WAIT.
- WAIT, mul_valid=1: rsp_p<=mul_p, rsp_err<=0; go to RESP.
- WAIT, mul_valid=0: watchdog increments. When watchdog==TIMEOUT: rsp_p<=0, rsp_err<=1, timeout_err<=1; go to RESP.
- WAIT, mul_valid=1 in the same cycle the watchdog hits TIMEOUT: valid wins, no error.
- RESP (1 cycle): rsp_valid=1 with rsp_id, rsp_p and rsp_err stable; go to IDLE.
- Latency: req seen in IDLE at cycle t gives gnt/mul_load at t+1, SETTLE at t+2, WAIT from t+3. rsp_valid comes one cycle after the first mul_valid sampled in WAIT.
- Minimum spacing between grants is 5 cycles; no re-arbitration before returning to IDLE.
- mul_a/mul_b hold their values from IDLE capture until the next capture.
- Requester drops req after seeing gnt. A req still high when back in IDLE is treated as a new request.
- Requests change only the next arbitration; they never pre-empt an operation in progress.
- Fairness: with all N requesting continuously, grants go strictly 0,1,...,N-1,0,...
- Product arithmetic is done by the multiplier; the arbiter passes 2*W bits through unmodified.

Decomposition:
- Package pes_seq_mul_pkg:
  - state enum (IDLE, LOAD, SETTLE, WAIT, RESP)
  - default widths W_DEF=8, N_DEF=4
  - TIMEOUT_DEF=31
  - ID width function clog2
- Sub-module pes_rr_arb: combinational round-robin picker. Inputs are req and pointer; outputs are found and id. It has no state; the pointer register stays in the parent.

Test Plan:
- Reset, then req=0001 with a0=255, b0=255 against the real multiplier -> gnt=0001 one cycle after req; rsp_valid with rsp_id=0, rsp_p=65025, rsp_err=0; busy low afterwards.
- Issue req=1111 at once with (25,5), (11,33), (128,0), (80,10), each requester dropping its req on gnt -> grants in order 0,1,2,3. Responses: id0=125, id1=363, id2=0, id3=800.
- Hold all req high for 8 ops with pointer starting at 1 -> grant sequence 2,3,0,1,2,3,0,1. Each gnt is exactly one cycle and one-hot.
- Stale-valid check: multiplier model holds mul_valid high after the op; issue a back-to-back op (64,64) -> result 4096, not the previous product.
- Model never asserts mul_valid, TIMEOUT=31 -> rsp_valid with rsp_err=1 and rsp_p=0 exactly 32 cycles after entering WAIT; timeout_err stays 1; the next op (36,36) returns 1296 with rsp_err=0.
- Assert rst for 2 cycles while in WAIT -> no rsp_valid; all outputs at reset values. The next req from requester 0 is granted first.
